// File: rtl/fadder_serial_if.sv
// fadder_serial_if -- operand/result handshake bundle for fadder_serial.
//
// Signals:
//   in_valid / in_ready   : operand handshake (producer -> adder)
//   A, B  [WIDTH-1:0]     : operands
//   Cin                   : carry-in (add) / borrow-in (subtract)
//   Sub                   : 0 = add, 1 = subtract
//   out_valid / out_ready : result handshake (adder -> consumer)
//   Sum   [WIDTH-1:0]     : result
//   Cout                  : carry-out (add) / no-borrow flag (subtract)
//   Ovf                   : two's-complement signed overflow
//
// Modports:
//   master : the side that supplies operands and consumes results
//   slave  : the adder itself
interface fadder_serial_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Ovf;

  modport master (
    output in_valid, A, B, Cin, Sub, out_ready,
    input  in_ready, out_valid, Sum, Cout, Ovf
  );

  modport slave (
    input  in_valid, A, B, Cin, Sub, out_ready,
    output in_ready, out_valid, Sum, Cout, Ovf
  );
endinterface

// File: rtl/fadder_serial.sv
// fadder_serial -- digit-serial adder/subtractor.
//
// Adds (or subtracts) two WIDTH-bit operands DIGIT bits per clock, least
// significant digit first, with a rippling carry register between digits.
// One operation is in flight at a time: IDLE accepts, RUN computes NDIG
// digits, DONE presents the result until the consumer takes it.
//
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : fadder_serial_if.slave (operand and result handshakes)
//
// Parameters:
//   WIDTH : operand/result width (>= 2)
//   DIGIT : bits per cycle, 1..WIDTH, must divide WIDTH
module fadder_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic           clk,
  input  logic           rst,
  fadder_serial_if.slave bus
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;     // already inverted for subtract
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [31:0]      dig_lo;       // bit position of the current digit
  logic [DIGIT-1:0] a_dig, b_dig, dig_sum;
  logic             dig_cout;
  logic             last_dig;
  logic             msb_cin;      // carry into bit WIDTH-1 on the last digit
  logic [WIDTH-1:0] slice_mask;

  assign dig_lo   = 32'(cnt_q) * 32'(DIGIT);
  assign a_dig    = DIGIT'(a_q >> dig_lo);
  assign b_dig    = DIGIT'(b_q >> dig_lo);

  // carry_q holds c0 for digit 0 (loaded at accept), then the ripple carry.
  assign {dig_cout, dig_sum} = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};

  assign last_dig   = (cnt_q == CW'(NDIG - 1));
  assign slice_mask = WIDTH'({DIGIT{1'b1}}) << dig_lo;

  // Sum bit = a ^ b ^ carry_in, so the carry into the top bit is recoverable
  // from the top bit of the digit without a separate partial adder.
  assign msb_cin = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ dig_sum[DIGIT-1];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.A;
          b_d     = bus.Sub ? ~bus.B : bus.B;
          carry_d = bus.Sub ? ~bus.Cin : bus.Cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = (sum_q & ~slice_mask) | (WIDTH'(dig_sum) << dig_lo);
        carry_d = dig_cout;
        if (last_dig) begin
          cout_d  = dig_cout;
          ovf_d   = msb_cin ^ dig_cout;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.Sum       = sum_q;
  assign bus.Cout      = cout_q;
  assign bus.Ovf       = ovf_q;

endmodule

// File: tb/tb_fadder_serial.sv
// tb_fadder_serial -- bench for fadder_serial.
//
// Three instances (WIDTH=8 with DIGIT=2, 1 and 8) share the same stimulus so
// every operation is checked against all three, including latency.
module tb_fadder_serial;

  logic clk;
  logic rst;

  logic       iv_s;
  logic [7:0] a_s, b_s;
  logic       cin_s, sub_s;
  logic       ordy_s;

  int n_checks = 0;
  int n_fail   = 0;

  fadder_serial_if #(.WIDTH(8)) if_d2 ();
  fadder_serial_if #(.WIDTH(8)) if_d1 ();
  fadder_serial_if #(.WIDTH(8)) if_d8 ();

  fadder_serial #(.WIDTH(8), .DIGIT(2)) dut_d2 (.clk(clk), .rst(rst), .bus(if_d2));
  fadder_serial #(.WIDTH(8), .DIGIT(1)) dut_d1 (.clk(clk), .rst(rst), .bus(if_d1));
  fadder_serial #(.WIDTH(8), .DIGIT(8)) dut_d8 (.clk(clk), .rst(rst), .bus(if_d8));

  assign if_d2.in_valid = iv_s;  assign if_d2.A = a_s;  assign if_d2.B = b_s;
  assign if_d2.Cin = cin_s;      assign if_d2.Sub = sub_s; assign if_d2.out_ready = ordy_s;
  assign if_d1.in_valid = iv_s;  assign if_d1.A = a_s;  assign if_d1.B = b_s;
  assign if_d1.Cin = cin_s;      assign if_d1.Sub = sub_s; assign if_d1.out_ready = ordy_s;
  assign if_d8.in_valid = iv_s;  assign if_d8.A = a_s;  assign if_d8.B = b_s;
  assign if_d8.Cin = cin_s;      assign if_d8.Sub = sub_s; assign if_d8.out_ready = ordy_s;

  // Index 0: DIGIT=2, 1: DIGIT=1, 2: DIGIT=8
  logic       ov  [3];
  logic       ir  [3];
  logic [7:0] sm  [3];
  logic       co  [3];
  logic       of  [3];
  assign ov[0] = if_d2.out_valid; assign ir[0] = if_d2.in_ready; assign sm[0] = if_d2.Sum;
  assign co[0] = if_d2.Cout;      assign of[0] = if_d2.Ovf;
  assign ov[1] = if_d1.out_valid; assign ir[1] = if_d1.in_ready; assign sm[1] = if_d1.Sum;
  assign co[1] = if_d1.Cout;      assign of[1] = if_d1.Ovf;
  assign ov[2] = if_d8.out_valid; assign ir[2] = if_d8.in_ready; assign sm[2] = if_d8.Sum;
  assign co[2] = if_d8.Cout;      assign of[2] = if_d8.Ovf;

  int exp_lat [3] = '{4, 8, 1};
  string nm   [3] = '{"d2", "d1", "d8"};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, cout, sum[7:0]}
  function automatic logic [9:0] model(input logic [7:0] a, b, input logic cin, sub);
    logic [7:0] beff;
    logic       c0;
    logic [8:0] full;
    logic       ovf;
    beff = sub ? ~b : b;
    c0   = sub ? ~cin : cin;
    full = {1'b0, a} + {1'b0, beff} + {8'd0, c0};
    ovf  = (a[7] == beff[7]) && (full[7] != a[7]);
    return {ovf, full};
  endfunction

  // One full transaction on all three instances with the given expectations.
  task automatic run_op(input logic [7:0] a, b, input logic cin, sub,
                        input logic [7:0] es, input logic ec, eo, input bit hold);
    int lat [3];
    lat = '{0, 0, 0};
    @(negedge clk);
    a_s = a; b_s = b; cin_s = cin; sub_s = sub; iv_s = 1'b1; ordy_s = 1'b0;
    @(posedge clk); #1;
    // Operands and in_valid wiggle after acceptance; none of it may matter.
    a_s = 8'($urandom); b_s = 8'($urandom); cin_s = 1'($urandom); sub_s = 1'($urandom);
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      for (int j = 0; j < 3; j++)
        if (lat[j] == 0 && ov[j]) lat[j] = k;
    end
    for (int j = 0; j < 3; j++) begin
      check($sformatf("latency_%s", nm[j]), 32'(lat[j]), 32'(exp_lat[j]));
      check($sformatf("sum_%s", nm[j]),  32'(sm[j]), 32'(es));
      check($sformatf("cout_%s", nm[j]), 32'(co[j]), 32'(ec));
      check($sformatf("ovf_%s", nm[j]),  32'(of[j]), 32'(eo));
    end
    if (hold) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        a_s = 8'($urandom); iv_s = 1'b1;
        @(posedge clk); #1;
        check("hold_out_valid", 32'(ov[0]), 32'd1);
        check("hold_in_ready",  32'(ir[0]), 32'd0);
        check("hold_sum",       32'(sm[0]), 32'(es));
        check("hold_cout",      32'(co[0]), 32'(ec));
      end
    end
    @(negedge clk);
    ordy_s = 1'b1; iv_s = 1'b0;
    @(posedge clk); #1;
    for (int j = 0; j < 3; j++) begin
      check($sformatf("release_in_ready_%s", nm[j]),  32'(ir[j]), 32'd1);
      check($sformatf("release_out_valid_%s", nm[j]), 32'(ov[j]), 32'd0);
    end
    ordy_s = 1'b0;
    $display("op A=%02h B=%02h Cin=%0d Sub=%0d -> Sum=%02h Cout=%0d Ovf=%0d (exp %02h %0d %0d) lat=%0d/%0d/%0d",
             a, b, cin, sub, sm[0], co[0], of[0], es, ec, eo, lat[0], lat[1], lat[2]);
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic       cin, sub;
    logic [7:0] es;
    logic       ec, eo;
  } vec_t;

  // Hand-computed: the last entry leaves Cout=1 and a nonzero Sum behind so
  // the reset check below has something to clear.
  vec_t vecs [7] = '{
    '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0},
    '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0},
    '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1},
    '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0},
    '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1},
    '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1},
    '{8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0}
  };

  initial begin
    logic [9:0] m;
    logic [7:0] ra, rb;
    logic       rc, rs;
    rst = 1'b1; iv_s = 1'b0; ordy_s = 1'b0;
    a_s = 8'h00; b_s = 8'h00; cin_s = 1'b0; sub_s = 1'b0;
    #3;
    check("reset_out_valid", 32'(ov[0]), 32'd0);
    check("reset_in_ready",  32'(ir[0]), 32'd1);
    check("reset_sum",       32'(sm[0]), 32'd0);
    check("reset_cout",      32'(co[0]), 32'd0);
    check("reset_ovf",       32'(of[0]), 32'd0);
    // Release just after an edge so run_op's accept lands on the first
    // rising edge after deassertion.
    @(posedge clk); #2 rst = 1'b0;

    for (int i = 0; i < 7; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
             vecs[i].es, vecs[i].ec, vecs[i].eo, i == 3);

    // Abort mid-RUN after two digits of the DIGIT=2 instance.
    @(negedge clk);
    a_s = 8'h55; b_s = 8'h55; cin_s = 1'b0; sub_s = 1'b0; iv_s = 1'b1;
    @(posedge clk); #1 iv_s = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrun_sum",       32'(sm[0]), 32'd0);
    check("midrun_cout",      32'(co[0]), 32'd0);
    check("midrun_ovf",       32'(of[0]), 32'd0);
    check("midrun_out_valid", 32'(ov[0]), 32'd0);
    check("midrun_in_ready",  32'(ir[0]), 32'd1);
    @(negedge clk) rst = 1'b0;
    $display("reset mid-run: Sum=%02h Cout=%0d Ovf=%0d out_valid=%0d in_ready=%0d",
             sm[0], co[0], of[0], ov[0], ir[0]);
    repeat (10) begin
      @(posedge clk); #1;
      check("midrun_no_result", 32'(ov[0] | ov[1] | ov[2]), 32'd0);
    end
    run_op(8'h55, 8'h55, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      m = model(ra, rb, rc, rs);
      run_op(ra, rb, rc, rs, m[7:0], m[8], m[9], 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fadder_serial.md
FADDER_SERIAL -- requirements
Module: fadder_serial

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal values are integers of 2 or more.
REQ-002 Parameter DIGIT, default 2, bits added per cycle; legal values are 1 to WIDTH and SHALL divide WIDTH exactly; NDIG = WIDTH/DIGIT.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operand set on A/B/Cin/Sub is valid.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 A  input  WIDTH  operand A.
REQ-008 B  input  WIDTH  operand B.
REQ-009 Cin  input  1  carry-in (add) / borrow-in (subtract).
REQ-010 Sub  input  1  0 = add, 1 = subtract.
REQ-011 out_valid  output  1  result on Sum/Cout/Ovf is valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 Sum  output  WIDTH  result.
REQ-014 Cout  output  1  carry-out (add) / no-borrow flag (subtract).
REQ-015 Ovf  output  1  two's-complement signed overflow.

Function
REQ-016 FSM states SHALL be IDLE, RUN, DONE; in_ready = (state==IDLE); out_valid = (state==DONE); both are decoded from registered state only.
REQ-017 IDLE: on in_valid && in_ready at a clock edge, the block SHALL latch A, B_eff, c0 and zero the digit counter, then go to RUN; otherwise it SHALL stay in IDLE.
REQ-018 Add (Sub=0): B_eff = B, c0 = Cin; result = A + B + Cin.
REQ-019 Subtract (Sub=1): B_eff = ~B, c0 = ~Cin; result = A - B - Cin mod 2^WIDTH.
REQ-020 RUN: each cycle, digit k (bits k*DIGIT+DIGIT-1 : k*DIGIT) = A_k + B_eff_k + carry; the DIGIT-bit sum goes to Sum slice k; the carry register takes the digit carry-out; the counter increments.
REQ-021 Digit 0 SHALL be computed first using c0; higher digits SHALL use the registered carry from the previous digit.
REQ-022 After digit NDIG-1, the FSM SHALL go to DONE with Cout = final carry and Ovf = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
REQ-023 Latency: accept at edge n; out_valid SHALL be high after edge n+NDIG (WIDTH=8, DIGIT=2: 4 cycles; DIGIT=WIDTH: 1 cycle).
REQ-024 DONE: Sum, Cout and Ovf SHALL hold stable while out_valid && !out_ready; on out_ready, the FSM SHALL return to IDLE at that edge.
REQ-025 in_valid SHALL be ignored in RUN and DONE; operand inputs may change freely after acceptance without affecting the result.
REQ-026 There is no same-cycle IDLE accept after DONE: at most one operation is in flight; throughput is 1 result per NDIG+2 cycles with out_ready held high.
REQ-027 Sum, Cout and Ovf SHALL retain the last result in IDLE; Sum slices are overwritten progressively during RUN and are undefined-for-use until out_valid.
REQ-028 The counter SHALL be max(1, clog2(NDIG)) bits and SHALL not wrap within one operation.

Reset
REQ-029 rst high SHALL immediately force state=IDLE and counter, carry, Sum, Cout, Ovf and latched operands to 0, with no clock required.
REQ-030 During and after reset, out_valid=0 and in_ready=1; reset in RUN or DONE SHALL abort the operation with no result produced.
REQ-031 The first accept SHALL be possible at the first rising edge after rst deasserts.

Verification (WIDTH=8, DIGIT=2 unless stated)
REQ-032 Add A=0x00, B=0x00, Cin=1 -> out_valid 4 cycles after accept; Sum=0x01, Cout=0, Ovf=0.
REQ-033 Add A=0xFF, B=0x01, Cin=0 -> Sum=0x00, Cout=1, Ovf=0; Add A=0x7F, B=0x01, Cin=0 -> Sum=0x80, Cout=0, Ovf=1.
REQ-034 Sub A=0x05, B=0x07, Cin=0 -> Sum=0xFE, Cout=0, Ovf=0; Sub A=0x80, B=0x01, Cin=0 -> Sum=0x7F, Cout=1, Ovf=1.
REQ-035 Backpressure: out_ready=0 for 3 cycles in DONE with in_valid=1 -> out_valid, Sum and Cout held; in_ready=0; no new accept; IDLE the edge after out_ready=1.
REQ-036 Reset mid-RUN (after 2 digits) -> Sum=0, Cout=0, Ovf=0, out_valid=0 and in_ready=1 without a clock edge; next operation correct.
REQ-037 Re-parameterise DIGIT=1 and DIGIT=8, with exhaustive random compare against A+B+Cin and A-B-Cin -> latency 8 and 1 cycles respectively; all results match.
